// File: rtl/mc_datapath_if.sv
`default_nettype none
// ============================================================================
// Module      : mc_datapath_if
// Description : Instruction and data memory req/ack bus for mc_datapath.
// Revision    : 1.0 - initial release
// ============================================================================
interface mc_datapath_if #(
    parameter int DATA_WIDTH = 32,
    parameter int PC_WIDTH   = 16
);
    logic                  imem_req;
    logic [PC_WIDTH-1:0]   imem_addr;
    logic                  imem_ack;
    logic [31:0]           imem_rdata;
    logic                  dmem_req;
    logic                  dmem_we;
    logic [PC_WIDTH-1:0]   dmem_addr;
    logic [DATA_WIDTH-1:0] dmem_wdata;
    logic                  dmem_ack;
    logic [DATA_WIDTH-1:0] dmem_rdata;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mc_datapath.sv
`default_nettype none
// ============================================================================
// Module      : mc_datapath
// Description : Multicycle datapath with integrated FETCH/DECODE/EXEC/MEM/WB
//               sequencer; memories sit behind req/ack handshakes.
//               Optional macro DP_TRAP_ILLEGAL_EN halts on unlisted opcodes.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_datapath #(
    parameter int DATA_WIDTH     = 32,
    parameter int PC_WIDTH       = 16,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    mc_datapath_if.master              mem,
    output logic [PC_WIDTH-1:0]        pc_out,
    output logic [DATA_WIDTH-1:0]      alu_out,
    output logic                       halted,
    output logic                       illegal
);
    localparam logic [2:0] c_st_fetch  = 3'd0;
    localparam logic [2:0] c_st_decode = 3'd1;
    localparam logic [2:0] c_st_exec   = 3'd2;
    localparam logic [2:0] c_st_mem    = 3'd3;
    localparam logic [2:0] c_st_wb     = 3'd4;
    localparam logic [2:0] c_st_halt   = 3'd5;

    localparam logic [5:0] c_op_alu  = 6'h00;
    localparam logic [5:0] c_op_addi = 6'h01;
    localparam logic [5:0] c_op_lui  = 6'h02;
    localparam logic [5:0] c_op_lw   = 6'h03;
    localparam logic [5:0] c_op_sw   = 6'h04;
    localparam logic [5:0] c_op_beq  = 6'h05;
    localparam logic [5:0] c_op_bne  = 6'h06;
    localparam logic [5:0] c_op_blt  = 6'h07;
    localparam logic [5:0] c_op_jmp  = 6'h08;
    localparam logic [5:0] c_op_halt = 6'h3F;

    logic [2:0]               r_state;
    logic [PC_WIDTH-1:0]      r_pc;
    logic [31:0]              r_ir;
    logic [DATA_WIDTH-1:0]    r_a;
    logic [DATA_WIDTH-1:0]    r_b;
    logic [DATA_WIDTH-1:0]    r_alu_out;
    logic [DATA_WIDTH-1:0]    r_mdr;
    logic                     r_imem_req;
    logic                     r_dmem_req;
    logic                     r_dmem_we;
    logic [PC_WIDTH-1:0]      r_dmem_addr;
    logic [DATA_WIDTH-1:0]    r_dmem_wdata;
    logic                     r_halted;
    logic [DATA_WIDTH-1:0]    r_regs [0:(1<<REG_ADDR_WIDTH)-1];

    logic [5:0]               w_opcode;
    logic [REG_ADDR_WIDTH-1:0] w_r1;
    logic [REG_ADDR_WIDTH-1:0] w_r2;
    logic [REG_ADDR_WIDTH-1:0] w_r3;
    logic [15:0]              w_imm;
    logic [2:0]               w_funct;
    logic [DATA_WIDTH-1:0]    w_rd_r1;
    logic [DATA_WIDTH-1:0]    w_rd_r2;
    logic [DATA_WIDTH-1:0]    w_rd_r3;
    logic [DATA_WIDTH-1:0]    w_imm_se;
    logic [DATA_WIDTH-1:0]    w_lui;
    logic [DATA_WIDTH-1:0]    w_alu_result;
    logic [PC_WIDTH-1:0]      w_br_target;
    logic [PC_WIDTH-1:0]      w_jmp_target;
    logic                     w_eq;
    logic                     w_lt;
    logic                     w_taken;

    assign w_opcode = r_ir[31:26];
    assign w_r1     = r_ir[21 +: REG_ADDR_WIDTH];
    assign w_r2     = r_ir[16 +: REG_ADDR_WIDTH];
    assign w_r3     = r_ir[11 +: REG_ADDR_WIDTH];
    assign w_imm    = r_ir[15:0];
    assign w_funct  = r_ir[2:0];

    assign w_rd_r1 = (w_r1 == '0) ? '0 : r_regs[w_r1];
    assign w_rd_r2 = (w_r2 == '0) ? '0 : r_regs[w_r2];
    assign w_rd_r3 = (w_r3 == '0) ? '0 : r_regs[w_r3];

    assign w_imm_se    = DATA_WIDTH'($signed(w_imm));
    assign w_lui       = DATA_WIDTH'(w_imm) << (DATA_WIDTH - 16);
    // PC already points past the branch, so the offset is relative to PC+1
    assign w_br_target = r_pc + PC_WIDTH'($signed(w_imm));

    // A holds reg[R2] and B holds reg[R1]: "R1 op R2" compares B against A
    assign w_eq = (r_b == r_a);
    assign w_lt = ($signed(r_b) < $signed(r_a));

    generate
        if (PC_WIDTH <= 26) begin : g_jmp_narrow
            assign w_jmp_target = r_ir[PC_WIDTH-1:0];
        end else begin : g_jmp_wide
            assign w_jmp_target = {{(PC_WIDTH-26){1'b0}}, r_ir[25:0]};
        end
    endgenerate

    always_comb begin
        w_alu_result = r_a + w_imm_se;
        if (w_opcode == c_op_alu) begin
            case (w_funct)
                3'd0:    w_alu_result = r_a + r_b;
                3'd1:    w_alu_result = r_a - r_b;
                3'd2:    w_alu_result = r_a & r_b;
                3'd3:    w_alu_result = r_a | r_b;
                3'd4:    w_alu_result = r_a ^ r_b;
                3'd5:    w_alu_result = DATA_WIDTH'($signed(r_a) < $signed(r_b));
                3'd6:    w_alu_result = r_a << r_b[4:0];
                default: w_alu_result = r_a >> r_b[4:0];
            endcase
        end else if (w_opcode == c_op_lui) begin
            w_alu_result = w_lui;
        end
    end

    always_comb begin
        w_taken = 1'b0;
        case (w_opcode)
            c_op_beq: w_taken = w_eq;
            c_op_bne: w_taken = !w_eq;
            c_op_blt: w_taken = w_lt;
            default:  w_taken = 1'b0;
        endcase
    end

`ifdef DP_TRAP_ILLEGAL_EN
    logic r_illegal;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_st_fetch;
            r_pc         <= '0;
            r_ir         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_alu_out    <= '0;
            r_mdr        <= '0;
            r_imem_req   <= 1'b0;
            r_dmem_req   <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_dmem_addr  <= '0;
            r_dmem_wdata <= '0;
            r_halted     <= 1'b0;
`ifdef DP_TRAP_ILLEGAL_EN
            r_illegal    <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_st_fetch: begin
                    // First FETCH after reset spends one cycle raising the request
                    if (!r_imem_req) begin
                        r_imem_req <= 1'b1;
                    end else if (mem.imem_ack) begin
                        r_ir       <= mem.imem_rdata;
                        r_pc       <= r_pc + 1'b1;
                        r_imem_req <= 1'b0;
                        r_state    <= c_st_decode;
                    end
                end
                c_st_decode: begin
                    r_a     <= w_rd_r2;
                    r_b     <= (w_opcode == c_op_alu) ? w_rd_r3 : w_rd_r1;
                    r_state <= c_st_exec;
                end
                c_st_exec: begin
                    r_alu_out <= w_alu_result;
                    case (w_opcode)
                        c_op_alu, c_op_addi, c_op_lui: begin
                            r_state <= c_st_wb;
                        end
                        c_op_lw, c_op_sw: begin
                            // Address/data are captured once and held for the whole access
                            r_dmem_req   <= 1'b1;
                            r_dmem_we    <= (w_opcode == c_op_sw);
                            r_dmem_addr  <= w_alu_result[PC_WIDTH-1:0];
                            r_dmem_wdata <= r_b;
                            r_state      <= c_st_mem;
                        end
                        c_op_beq, c_op_bne, c_op_blt: begin
                            if (w_taken) begin
                                r_pc <= w_br_target;
                            end
                            r_imem_req <= 1'b1;
                            r_state    <= c_st_fetch;
                        end
                        c_op_jmp: begin
                            r_pc       <= w_jmp_target;
                            r_imem_req <= 1'b1;
                            r_state    <= c_st_fetch;
                        end
                        c_op_halt: begin
                            r_halted <= 1'b1;
                            r_state  <= c_st_halt;
                        end
                        default: begin
`ifdef DP_TRAP_ILLEGAL_EN
                            r_halted  <= 1'b1;
                            r_illegal <= 1'b1;
                            r_state   <= c_st_halt;
`else
                            r_imem_req <= 1'b1;
                            r_state    <= c_st_fetch;
`endif
                        end
                    endcase
                end
                c_st_mem: begin
                    if (mem.dmem_ack) begin
                        r_dmem_req <= 1'b0;
                        if (r_dmem_we) begin
                            r_imem_req <= 1'b1;
                            r_state    <= c_st_fetch;
                        end else begin
                            r_mdr   <= mem.dmem_rdata;
                            r_state <= c_st_wb;
                        end
                    end
                end
                c_st_wb: begin
                    r_imem_req <= 1'b1;
                    r_state    <= c_st_fetch;
                end
                c_st_halt: begin
                    r_state <= c_st_halt;
                end
                default: begin
                    r_state <= c_st_fetch;
                end
            endcase
        end
    end

    // Register file is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (!reset && (r_state == c_st_wb) && (w_r1 != '0)) begin
            r_regs[w_r1] <= (w_opcode == c_op_lw) ? r_mdr : r_alu_out;
        end
    end

    assign mem.imem_req   = r_imem_req;
    assign mem.imem_addr  = r_pc;
    assign mem.dmem_req   = r_dmem_req;
    assign mem.dmem_we    = r_dmem_we;
    assign mem.dmem_addr  = r_dmem_addr;
    assign mem.dmem_wdata = r_dmem_wdata;

    assign pc_out  = r_pc;
    assign alu_out = r_alu_out;
    assign halted  = r_halted;
`ifdef DP_TRAP_ILLEGAL_EN
    assign illegal = r_illegal;
`else
    assign illegal = 1'b0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_mc_datapath.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_datapath
// Description : Directed self-checking bench for mc_datapath with a
//               variable-latency instruction/data memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_datapath;
    localparam int DW = 32;
    localparam int PW = 16;
    localparam logic [31:0] HALT_I = 32'hFC00_0000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mc_datapath_if #(.DATA_WIDTH(DW), .PC_WIDTH(PW)) mif ();
    logic [PW-1:0] pc_out;
    logic [DW-1:0] alu_out;
    logic          halted;
    logic          illegal;

    mc_datapath #(.DATA_WIDTH(DW), .PC_WIDTH(PW), .REG_ADDR_WIDTH(5)) dut (
        .clk     (clk),
        .reset   (reset),
        .mem     (mif.master),
        .pc_out  (pc_out),
        .alu_out (alu_out),
        .halted  (halted),
        .illegal (illegal)
    );

    logic [31:0]   imem [0:63];
    logic [DW-1:0] dmem [0:255];
    int            imem_wait, dmem_wait, i_cnt, d_cnt, cyc, nfetch;
    int            fetch_cyc [0:63];
    logic [PW-1:0] fetch_pc  [0:63];
    logic [DW-1:0] alu_snap  [0:63];
    int            checks = 0;
    int            errors = 0;

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] r1,
                                          input logic [4:0] r2, input logic [15:0] imm);
        return {op, r1, r2, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] r1, input logic [4:0] r2,
                                          input logic [4:0] r3, input logic [2:0] funct);
        return {6'h00, r1, r2, r3, 8'h00, funct};
    endfunction

    // Advance one cycle; memory model acts on the falling edge
    task automatic tick();
        @(negedge clk);
        cyc++;
        mif.imem_ack = 1'b0;
        mif.dmem_ack = 1'b0;
        if (reset) begin
            i_cnt = 0;
            d_cnt = 0;
        end else begin
            if (mif.imem_req) begin
                if (i_cnt >= imem_wait) begin
                    mif.imem_ack   = 1'b1;
                    mif.imem_rdata = imem[mif.imem_addr[5:0]];
                    if (nfetch < 64) begin
                        fetch_cyc[nfetch] = cyc;
                        fetch_pc[nfetch]  = mif.imem_addr;
                        alu_snap[nfetch]  = alu_out;
                    end
                    nfetch++;
                    i_cnt = 0;
                end else begin
                    i_cnt++;
                end
            end else begin
                i_cnt = 0;
            end
            if (mif.dmem_req) begin
                if (d_cnt >= dmem_wait) begin
                    mif.dmem_ack = 1'b1;
                    if (mif.dmem_we) dmem[mif.dmem_addr[7:0]] = mif.dmem_wdata;
                    else             mif.dmem_rdata = dmem[mif.dmem_addr[7:0]];
                    d_cnt = 0;
                end else begin
                    d_cnt++;
                end
            end else begin
                d_cnt = 0;
            end
        end
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 64; i++) imem[i] = HALT_I;
    endtask

    task automatic start_prog(input int iw, input int dw);
        reset = 1'b1;
        imem_wait = iw;
        dmem_wait = dw;
        repeat (3) tick();
        nfetch = 0;
        cyc    = 0;
        reset  = 1'b0;
    endtask

    task automatic run_until_halted(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            if (halted) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        checks += 6;
        if (mif.imem_req !== 1'b0) begin errors++; $display("FAIL reset_imem_req: got %0b want 0", mif.imem_req); end
        if (mif.dmem_req !== 1'b0) begin errors++; $display("FAIL reset_dmem_req: got %0b want 0", mif.dmem_req); end
        if (pc_out !== '0)         begin errors++; $display("FAIL reset_pc: got %0h want 0", pc_out); end
        if (alu_out !== '0)        begin errors++; $display("FAIL reset_alu_out: got %0h want 0", alu_out); end
        if (halted !== 1'b0)       begin errors++; $display("FAIL reset_halted: got %0b want 0", halted); end
        if (illegal !== 1'b0)      begin errors++; $display("FAIL reset_illegal: got %0b want 0", illegal); end
    endtask

    task automatic test_alu_program();
        bit ok;
        clear_imem();
        imem[0] = enc_i(6'h01, 5'd1, 5'd0, 16'd5);
        imem[1] = enc_i(6'h01, 5'd2, 5'd0, 16'hFFFD);
        imem[2] = enc_r(5'd3, 5'd1, 5'd2, 3'd0);
        imem[3] = enc_i(6'h04, 5'd3, 5'd0, 16'h0008);
        dmem[8] = '0;
        start_prog(0, 0);
        run_until_halted(200, ok);
        checks += 5;
        if (!ok) begin errors++; $display("FAIL alu_prog_halt: got no halt want halt"); end
        if (fetch_cyc[3] - fetch_cyc[0] !== 12) begin
            errors++; $display("FAIL alu_prog_cycles: got %0d want 12", fetch_cyc[3] - fetch_cyc[0]);
        end
        if (alu_snap[3] !== 32'd2) begin errors++; $display("FAIL alu_prog_alu_out: got %0h want 2", alu_snap[3]); end
        if (dmem[8] !== 32'd2)     begin errors++; $display("FAIL alu_prog_r3: got %0h want 2", dmem[8]); end
        if (pc_out !== 16'd5)      begin errors++; $display("FAIL alu_prog_pc: got %0h want 5", pc_out); end
    endtask

    task automatic test_alu_ops();
        bit ok;
        logic [2:0]  fn [9] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7};
        logic [4:0]  sa [9] = '{5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd2, 5'd1, 5'd2};
        logic [4:0]  sb [9] = '{5'd2, 5'd2, 5'd2, 5'd2, 5'd2, 5'd2, 5'd1, 5'd4, 5'd4};
        logic [31:0] ex [9] = '{32'h0000_0002, 32'h0000_0008, 32'h0000_0005, 32'hFFFF_FFFD,
                               32'hFFFF_FFF8, 32'h0000_0000, 32'h0000_0001, 32'h0000_0050,
                               32'h0FFF_FFFF};
        clear_imem();
        imem[0] = enc_i(6'h01, 5'd1, 5'd0, 16'd5);
        imem[1] = enc_i(6'h01, 5'd2, 5'd0, 16'hFFFD);
        imem[2] = enc_i(6'h01, 5'd4, 5'd0, 16'd4);
        for (int i = 0; i < 9; i++) imem[3+i] = enc_r(5'd3, sa[i], sb[i], fn[i]);
        start_prog(0, 0);
        run_until_halted(300, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL alu_ops_halt: got no halt want halt"); end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (alu_snap[4+i] !== ex[i]) begin
                errors++; $display("FAIL alu_op_%0d: got %0h want %0h", i, alu_snap[4+i], ex[i]);
            end
        end
    endtask

    task automatic test_load_store();
        bit ok;
        clear_imem();
        imem[0] = enc_i(6'h02, 5'd4, 5'd0, 16'hABCD);
        imem[1] = enc_i(6'h04, 5'd4, 5'd0, 16'h0010);
        imem[2] = enc_i(6'h03, 5'd5, 5'd0, 16'h0010);
        imem[3] = enc_i(6'h04, 5'd5, 5'd0, 16'h0011);
        dmem[8'h10] = '0;
        dmem[8'h11] = '0;
        start_prog(0, 3);
        run_until_halted(300, ok);
        checks += 6;
        if (!ok) begin errors++; $display("FAIL ldst_halt: got no halt want halt"); end
        if (alu_snap[1] !== 32'hABCD_0000) begin errors++; $display("FAIL ldst_lui: got %0h want abcd0000", alu_snap[1]); end
        if (dmem[8'h10] !== 32'hABCD_0000) begin errors++; $display("FAIL ldst_sw_mem: got %0h want abcd0000", dmem[8'h10]); end
        if (dmem[8'h11] !== 32'hABCD_0000) begin errors++; $display("FAIL ldst_lw_r5: got %0h want abcd0000", dmem[8'h11]); end
        if (fetch_cyc[2] - fetch_cyc[1] !== 7) begin
            errors++; $display("FAIL ldst_sw_cycles: got %0d want 7", fetch_cyc[2] - fetch_cyc[1]);
        end
        if (fetch_cyc[3] - fetch_cyc[2] !== 8) begin
            errors++; $display("FAIL ldst_lw_cycles: got %0d want 8", fetch_cyc[3] - fetch_cyc[2]);
        end
    endtask

    task automatic test_branches();
        bit ok;
        // BLT taken backwards from PC 7
        clear_imem();
        imem[0] = enc_i(6'h01, 5'd1, 5'd0, 16'hFFFF);
        imem[1] = enc_i(6'h01, 5'd2, 5'd0, 16'd1);
        imem[2] = {6'h08, 26'd7};
        imem[7] = enc_i(6'h07, 5'd1, 5'd2, 16'hFFFE);
        start_prog(0, 0);
        run_until_halted(200, ok);
        checks += 6;
        if (!ok) begin errors++; $display("FAIL blt_halt: got no halt want halt"); end
        if (fetch_pc[3] !== 16'd7) begin errors++; $display("FAIL jmp_target: got %0h want 7", fetch_pc[3]); end
        if (fetch_pc[4] !== 16'd6) begin errors++; $display("FAIL blt_target: got %0h want 6", fetch_pc[4]); end
        if (fetch_cyc[3] - fetch_cyc[2] !== 3) begin
            errors++; $display("FAIL jmp_cycles: got %0d want 3", fetch_cyc[3] - fetch_cyc[2]);
        end
        if (fetch_cyc[4] - fetch_cyc[3] !== 3) begin
            errors++; $display("FAIL blt_cycles: got %0d want 3", fetch_cyc[4] - fetch_cyc[3]);
        end
        if (pc_out !== 16'd7) begin errors++; $display("FAIL blt_halt_pc: got %0h want 7", pc_out); end

        // BEQ not taken at PC 7, then BNE taken forward
        imem[7] = enc_i(6'h05, 5'd1, 5'd2, 16'hFFFE);
        imem[8] = enc_i(6'h06, 5'd1, 5'd2, 16'd2);
        start_prog(0, 0);
        run_until_halted(200, ok);
        checks += 5;
        if (!ok) begin errors++; $display("FAIL beq_halt: got no halt want halt"); end
        if (fetch_pc[4] !== 16'd8)  begin errors++; $display("FAIL beq_fallthrough: got %0h want 8", fetch_pc[4]); end
        if (fetch_pc[5] !== 16'd11) begin errors++; $display("FAIL bne_target: got %0h want b", fetch_pc[5]); end
        if (fetch_cyc[4] - fetch_cyc[3] !== 3) begin
            errors++; $display("FAIL beq_cycles: got %0d want 3", fetch_cyc[4] - fetch_cyc[3]);
        end
        if (pc_out !== 16'd12) begin errors++; $display("FAIL bne_halt_pc: got %0h want c", pc_out); end
    endtask

    task automatic test_reset_mid_store();
        bit seen = 1'b0;
        clear_imem();
        imem[0] = enc_i(6'h01, 5'd1, 5'd0, 16'h0055);
        imem[1] = enc_i(6'h04, 5'd1, 5'd0, 16'h0020);
        dmem[8'h20] = 32'hDEAD_BEEF;
        start_prog(0, 20);
        for (int i = 0; i < 30 && !seen; i++) begin
            tick();
            if (mif.dmem_req) seen = 1'b1;
        end
        checks += 3;
        if (!seen) begin errors++; $display("FAIL rst_mid_req_seen: got no dmem_req want dmem_req"); end
        if (mif.dmem_we !== 1'b1) begin errors++; $display("FAIL rst_mid_we: got %0b want 1", mif.dmem_we); end
        if (mif.dmem_addr !== 16'h0020) begin errors++; $display("FAIL rst_mid_addr: got %0h want 20", mif.dmem_addr); end
        reset = 1'b1;
        tick();
        checks += 4;
        if (mif.dmem_req !== 1'b0) begin errors++; $display("FAIL rst_mid_dmem_req: got %0b want 0", mif.dmem_req); end
        if (mif.imem_req !== 1'b0) begin errors++; $display("FAIL rst_mid_imem_req: got %0b want 0", mif.imem_req); end
        if (pc_out !== '0)         begin errors++; $display("FAIL rst_mid_pc: got %0h want 0", pc_out); end
        if (alu_out !== '0)        begin errors++; $display("FAIL rst_mid_alu_out: got %0h want 0", alu_out); end
        reset = 1'b0;
        tick();
        checks += 3;
        if (mif.imem_req !== 1'b1)  begin errors++; $display("FAIL rst_mid_refetch: got %0b want 1", mif.imem_req); end
        if (mif.imem_addr !== '0)   begin errors++; $display("FAIL rst_mid_fetch_addr: got %0h want 0", mif.imem_addr); end
        if (dmem[8'h20] !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL rst_mid_no_write: got %0h want deadbeef", dmem[8'h20]);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_illegal();
        bit ok;
        clear_imem();
        imem[0] = enc_i(6'h01, 5'd1, 5'd0, 16'd1);
        imem[1] = {6'h2A, 26'd0};
        imem[2] = enc_i(6'h01, 5'd2, 5'd0, 16'd3);
        imem[3] = enc_i(6'h04, 5'd2, 5'd0, 16'h0030);
        dmem[8'h30] = '0;
        start_prog(0, 0);
        run_until_halted(200, ok);
        checks += 4;
        if (!ok) begin errors++; $display("FAIL illegal_halt: got no halt want halt"); end
`ifdef DP_TRAP_ILLEGAL_EN
        if (illegal !== 1'b1) begin errors++; $display("FAIL illegal_flag: got %0b want 1", illegal); end
        if (pc_out !== 16'd2) begin errors++; $display("FAIL illegal_pc: got %0h want 2", pc_out); end
        if (nfetch !== 2)     begin errors++; $display("FAIL illegal_fetches: got %0d want 2", nfetch); end
        repeat (10) tick();
        checks += 3;
        if (nfetch !== 2)          begin errors++; $display("FAIL illegal_no_refetch: got %0d want 2", nfetch); end
        if (mif.imem_req !== 1'b0) begin errors++; $display("FAIL illegal_imem_req: got %0b want 0", mif.imem_req); end
        if (halted !== 1'b1)       begin errors++; $display("FAIL illegal_sticky: got %0b want 1", halted); end
`else
        if (illegal !== 1'b0)       begin errors++; $display("FAIL nop_flag: got %0b want 0", illegal); end
        if (dmem[8'h30] !== 32'd3)  begin errors++; $display("FAIL nop_continues: got %0h want 3", dmem[8'h30]); end
        if (fetch_cyc[2] - fetch_cyc[1] !== 3) begin
            errors++; $display("FAIL nop_cycles: got %0d want 3", fetch_cyc[2] - fetch_cyc[1]);
        end
`endif
    endtask

    task automatic test_r0();
        bit ok;
        clear_imem();
        imem[0] = enc_i(6'h01, 5'd6, 5'd0, 16'd7);
        imem[1] = enc_i(6'h01, 5'd0, 5'd0, 16'd9);
        imem[2] = enc_r(5'd6, 5'd0, 5'd0, 3'd0);
        imem[3] = enc_i(6'h04, 5'd6, 5'd0, 16'h0040);
        dmem[8'h40] = 32'h0000_1234;
        start_prog(1, 1);
        run_until_halted(300, ok);
        checks += 4;
        if (!ok) begin errors++; $display("FAIL r0_halt: got no halt want halt"); end
        if (alu_snap[2] !== 32'd9) begin errors++; $display("FAIL r0_addi_result: got %0h want 9", alu_snap[2]); end
        if (alu_snap[3] !== 32'd0) begin errors++; $display("FAIL r0_add_result: got %0h want 0", alu_snap[3]); end
        if (dmem[8'h40] !== 32'd0) begin errors++; $display("FAIL r0_r6_stored: got %0h want 0", dmem[8'h40]); end
    endtask

    initial begin
        mif.imem_ack   = 1'b0;
        mif.imem_rdata = '0;
        mif.dmem_ack   = 1'b0;
        mif.dmem_rdata = '0;
        imem_wait = 0;
        dmem_wait = 0;
        i_cnt  = 0;
        d_cnt  = 0;
        cyc    = 0;
        nfetch = 0;
        for (int i = 0; i < 256; i++) dmem[i] = '0;
        clear_imem();
        test_reset();
        test_alu_program();
        test_alu_ops();
        test_load_store();
        test_branches();
        test_reset_mid_store();
        test_illegal();
        test_r0();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
